ksa_pipe: RTL
=============

# ksa_pipe

Parametrised, pipelined Kogge-Stone adder with a valid/ready stream interface on both sides. It generalises the fixed 8-bit combinational KSA to any `WIDTH`, adds carry-in, signed overflow, tag passthrough and configurable register insertion between prefix levels. It sits in the datapath library as the drop-in wide adder for clocked designs that need a timing-closed add at full throughput.

## Interface
Parameters:
- `WIDTH`, 16: operand and sum width; at least 2, any value (not restricted to powers of 2).
- `REG_EVERY`, 2: number of prefix levels between pipeline registers; range 1..`LEVELS`.
- `TAG_W`, 4: width of the sideband tag carried alongside each operation; at least 1.
- Derived: `LEVELS` = ceil(log2(`WIDTH`)); `LAT` = ceil(`LEVELS`/`REG_EVERY`) + 1.

Ports:
- `clk` input 1: the single clock; all state is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand beat present.
- `in_ready` output 1: the block accepts a beat this cycle.
- `a` input `WIDTH`: first operand.
- `b` input `WIDTH`: second operand.
- `cin` input 1: carry-in.
- `in_tag` input `TAG_W`: sideband tag, returned unchanged with the result.
- `sub` input 1: present only with `KSA_PIPE_SUB_EN`; when 1, the block computes a − b.
- `out_valid` output 1: result beat present.
- `out_ready` input 1: the downstream consumer accepts the result.
- `sum` output `WIDTH`: result.
- `cout` output 1: carry out of bit `WIDTH`−1.
- `ovf` output 1: two's-complement signed overflow.
- `out_tag` output `TAG_W`: tag of the operation.

## Operation
- Stage 0 computes per-bit g = a&b and p = a^b. The carry-in is folded in as a generate into bit position −1, i.e. g0' = g0 | (p0 & cin).
- Prefix network: standard Kogge-Stone. At level k, node i combines with node i−2^k; nodes with i < 2^k pass through unchanged.
  - Operator: G = Gi | (Pi & Gj); P = Pi & Pj.
- Final stage:
  - sum[i] = p[i] ^ c[i−1], with c[−1] = cin.
  - cout = G[WIDTH−1].
  - ovf = c[WIDTH−1] ^ c[WIDTH−2].
- Register placement:
  - One register boundary after stage 0.
  - One register boundary after every `REG_EVERY` prefix levels. The last group merges into the output register that holds sum/cout/ovf/out_tag/out_valid.
  - Total register boundaries = `LAT`.
- Each stage carries a valid bit and the tag.
- Flow control is a global-advance pipeline: adv = !out_valid | out_ready. When adv = 1, every stage shifts one position, and empty stages (bubbles) shift like full ones. Bubbles are not collapsed.
- in_ready = adv, combinational from out_valid and out_ready. A beat is accepted when in_valid & in_ready.
- While out_valid & !out_ready: every stage holds. out_valid, sum, cout, ovf and out_tag are stable until accepted.
- Arithmetic is modulo 2^`WIDTH`. No saturation.

## Timing
- Reset (rst_n low, asynchronous): all valid bits are 0; out_valid=0; sum, cout, ovf and out_tag are 0. Internal data registers need no reset.
- Reset asserted mid-operation drops every in-flight beat. The first accept is possible on the first rising edge after rst_n deasserts; in_ready=1 at that point.
- Latency: a beat accepted at edge N produces out_valid=1 after edge N+`LAT` − 1. With out_ready held at 1, that is `LAT` cycles from accept to visible result. Example: `WIDTH`=16, `REG_EVERY`=2 gives `LAT`=3.
- Throughput: one beat per cycle when out_ready=1.
- Ordering: results emerge in acceptance order and tags are never reordered.
- Simultaneous events:
  - out_valid & out_ready together with a new in_valid: both the output and the input transfer in the same cycle.
  - in_valid with in_ready=0: the beat is not taken. The source must hold a, b, cin, in_tag and sub stable until it is accepted.

## Configuration
- `KSA_PIPE_SUB_EN` defined:
  - The `sub` port exists.
  - When sub=1, the operand b is inverted in stage 0 and the effective carry-in is !cin. The result is a − b − cin (borrow semantics): cout=1 means no borrow, and ovf is the signed subtraction overflow.
  - sub is pipelined with the beat.
- `KSA_PIPE_SUB_EN` undefined: no `sub` port, and the block always adds.

## Test plan
- `WIDTH`=16, `REG_EVERY`=2, out_ready=1:
  - a=0xFFFF, b=0x0001, cin=0, tag=3 → after 3 cycles: sum=0x0000, cout=1, ovf=0, out_tag=3.
  - a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
  - a=0x1234, b=0x0000, cin=1 → sum=0x1235, cout=0.
- Throughput: 8 back-to-back beats a=i, b=2i, tags 0..7 → 8 consecutive out_valid cycles with sum=3i, in order.
- Backpressure: out_ready=0 for 4 cycles while a result is valid → in_ready=0 and outputs frozen. out_ready=1 then releases the results in order, with no loss or duplication.
- Reset mid-stream: rst_n pulsed low with 2 beats in flight → out_valid=0 immediately, neither beat is ever emitted, and the next beat takes `LAT` cycles.
- With `KSA_PIPE_SUB_EN`: sub=1, a=0x0005, b=0x0007, cin=0 → sum=0xFFFE, cout=0. sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, ovf=1.
- Parameter sweep: `WIDTH` in {2, 13, 32, 64} and `REG_EVERY` in {1, `LEVELS`}, with 10k random beats checked against a+b+cin using a reference model and latency checked equal to `LAT`.

Source files
------------

// File: rtl/ksa_pipe.sv
// ksa_pipe: pipelined Kogge-Stone adder with valid/ready streams, carry-in, signed overflow and tag passthrough; define KSA_PIPE_SUB_EN to add the sub port (a - b - cin)
module ksa_pipe #(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [TAG_W-1:0] in_tag,
`ifdef KSA_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NGRP   = (LEVELS + REG_EVERY - 1) / REG_EVERY;
  logic             w_adv, w_sub, w_ci;
  logic [WIDTH-1:0] w_b, w_p0, w_g0, w_g, w_p, w_gf, w_p_fin, w_sum;
  logic             w_c_fin;
  logic [WIDTH-1:0] w_gg [NGRP];
  logic [WIDTH-1:0] w_pg [NGRP];
  logic [WIDTH-1:0] r_g [NGRP];
  logic [WIDTH-1:0] r_pp [NGRP];
  logic [WIDTH-1:0] r_p [NGRP];
  logic             r_c [NGRP];
  logic [TAG_W-1:0] r_tag [NGRP];
  logic [NGRP:0]    r_v;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf;
  logic [TAG_W-1:0] r_out_tag;
`ifdef KSA_PIPE_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif
  assign w_adv     = !r_v[NGRP] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v[NGRP];
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_tag   = r_out_tag;
  // stage 0: per-bit generate/propagate, subtraction folded in as ~b with inverted carry-in, carry-in folded into bit 0
  always_comb begin
    w_b  = w_sub ? ~b : b;
    w_ci = cin ^ w_sub;
    w_p0 = a ^ w_b;
    w_g0 = (a & w_b) | {{(WIDTH-1){1'b0}}, w_p0[0] & w_ci};
  end
  // prefix levels, each group of REG_EVERY levels starting from its register boundary
  always_comb begin
    w_g  = '0;
    w_p  = '0;
    w_gg = '{default: '0};
    w_pg = '{default: '0};
    for (int l = 0; l < LEVELS; l++) begin
      if (l % REG_EVERY == 0) begin
        w_g = r_g[l / REG_EVERY];
        w_p = r_pp[l / REG_EVERY];
      end
      w_g = w_g | (w_p & (w_g << (1 << l)));
      w_p = w_p & ((w_p << (1 << l)) | ~({WIDTH{1'b1}} << (1 << l)));
      if ((l + 1) % REG_EVERY == 0 || l == LEVELS - 1) begin
        w_gg[l / REG_EVERY] = w_g;
        w_pg[l / REG_EVERY] = w_p;
      end
    end
  end
  // final stage: group carries become bit carries; c[-1] is the effective carry-in
  always_comb begin
    w_gf    = w_gg[NGRP-1];
    w_p_fin = r_p[NGRP-1];
    w_c_fin = r_c[NGRP-1];
    w_sum   = w_p_fin ^ {w_gf[WIDTH-2:0], w_c_fin};
  end
  // datapath pipeline registers; contents of bubbles are don't-care so no reset
  always_ff @(posedge clk)
    if (w_adv) begin
      r_g[0]   <= w_g0;
      r_pp[0]  <= w_p0;
      r_p[0]   <= w_p0;
      r_c[0]   <= w_ci;
      r_tag[0] <= in_tag;
      for (int j = 1; j < NGRP; j++) begin
        r_g[j]   <= w_gg[j-1];
        r_pp[j]  <= w_pg[j-1];
        r_p[j]   <= r_p[j-1];
        r_c[j]   <= r_c[j-1];
        r_tag[j] <= r_tag[j-1];
      end
    end
  // valid chain and output register, all shifting together on global advance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_v       <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_out_tag <= '0;
    end else if (w_adv) begin
      r_v       <= {r_v[NGRP-1:0], in_valid};
      r_sum     <= w_sum;
      r_cout    <= w_gf[WIDTH-1];
      r_ovf     <= w_gf[WIDTH-1] ^ w_gf[WIDTH-2];
      r_out_tag <= r_tag[NGRP-1];
    end
endmodule
